mips_data_bus_bridge: RTL and testbench
=======================================

# mips_data_bus_bridge

Wait-state-tolerant bridge between the CPU data port and a variable-latency data memory. It registers every CPU load/store and drives it onto an Avalon-style memory bus, honouring `mem_waitrequest`. It returns `cpu_stall` to the core, which gates the core's clock enable, and buffers read data for the core. A watchdog aborts transfers that never complete.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in ACCESS with `mem_waitrequest` high before abort; legal range 1..65535.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_address` in 32: byte address from the core.
- `cpu_read` in 1: load request, level, held until stall drops.
- `cpu_write` in 1: store request, level, held until stall drops.
- `cpu_byteenable` in 4: lane enables from the core.
- `cpu_writedata` in 32: store data.
- `cpu_readdata` out 32: registered load result.
- `cpu_stall` out 1: combinational; core must not advance while high.
- `mem_address` out 32: registered word address (`cpu_address & 32'hFFFF_FFFC`).
- `mem_read` out 1: registered read strobe.
- `mem_write` out 1: registered write strobe.
- `mem_byteenable` out 4: registered copy of `cpu_byteenable`.
- `mem_writedata` out 32: registered copy of `cpu_writedata`.
- `mem_readdata` in 32: valid in the cycle `mem_read=1` and `mem_waitrequest=0`.
- `mem_waitrequest` in 1: slave not ready; the master holds all mem outputs stable.
- `bus_error` out 1: sticky; set on timeout, cleared only by reset.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stall=0, mem strobes low.
  - `cpu_read|cpu_write`: stall=1 combinationally. At the edge, latch address (low 2 bits cleared), byteenable and writedata into mem outputs, assert the strobe, clear the timeout counter, go to ACCESS.
- Simultaneous `cpu_read` and `cpu_write`: treated as a write only; `mem_read` stays 0.
- ACCESS:
  - stall=1; mem outputs held constant.
  - `mem_waitrequest=0`: drop the strobe at the edge and go to DONE. For reads, capture `mem_readdata` into `cpu_readdata`.
  - `mem_waitrequest=1`: counter increments. If the counter equals TIMEOUT-1 and wait is still high, abort: drop the strobe, set `bus_error`, load `cpu_readdata` with 0, go to DONE.
- DONE:
  - stall=0 for exactly one cycle; the core completes its instruction on this edge.
  - Always go to IDLE next, regardless of the request inputs.
- `cpu_readdata` holds its value until the next completed or aborted read. Writes do not modify it.
- The bridge does no lane shifting. Byte/half extraction remains in the core.
- Counter width is 16 bits; the counter saturates and never wraps inside ACCESS.

## Timing
- Reset values:
  - state IDLE
  - `mem_read=0`, `mem_write=0`
  - `mem_address=0`, `mem_byteenable=0`, `mem_writedata=0`
  - `cpu_readdata=0`
  - `bus_error=0`
  - counter 0
- `cpu_stall` after reset follows IDLE rules.
- Reset mid-ACCESS: strobes low on the edge following the reset cycle. The transfer is discarded and `cpu_readdata` goes to 0.
- Zero-wait memory: request seen in cycle N (IDLE, stall=1); strobe in N+1 (ACCESS, stall=1); DONE in N+2 (stall=0). That is 2 stall cycles per access.
- Each wait-state cycle adds one stall cycle.
- Timeout path: the strobe is high for exactly TIMEOUT cycles; DONE follows on the next cycle.
- Back-to-back accesses: a new request in the cycle after DONE starts a fresh IDLE→ACCESS sequence. The minimum spacing is 3 cycles per access.
- Changes on the CPU inputs during ACCESS/DONE are ignored.

## Test plan
- Zero-wait read:
  - Stimulus: `cpu_read=1`, `cpu_address=0x1000_0006`, memory returns 0xDEADBEEF with wait=0.
  - Required: `mem_address=0x1000_0004` and `mem_read=1` for exactly 1 cycle; stall high 2 cycles; `cpu_readdata=0xDEADBEEF` in DONE.
- Waited write:
  - Stimulus: `cpu_write=1`, `cpu_byteenable=4'b0011`, data 0x0000_1234, `mem_waitrequest` high 3 cycles.
  - Required: `mem_write` high 4 cycles with stable outputs; stall high 5 cycles; `cpu_readdata` unchanged.
- Timeout:
  - Stimulus: TIMEOUT=4, `mem_waitrequest` stuck at 1, read issued.
  - Required: strobe high 4 cycles; `bus_error=1` and stays set; `cpu_readdata=0`; stall drops one cycle later; the next access proceeds normally.
- Read+write conflict:
  - Stimulus: `cpu_read=1` and `cpu_write=1` together.
  - Required: only `mem_write` asserted; `mem_read` never asserted.
- Reset mid-ACCESS:
  - Stimulus: assert reset while `mem_waitrequest=1` during a read.
  - Required: the next cycle shows state IDLE, strobes 0, `cpu_readdata=0`, `bus_error=0`.
- Back-to-back:
  - Stimulus: read, then write, then read, all zero-wait.
  - Required: exactly 3 strobe pulses 3 cycles apart; stall pattern 1,1,0 repeated.

Source files
------------

// File: rtl/mips_data_bus_bridge.sv
// Registered bridge from the CPU data port to an Avalon-style memory bus.
// It stalls the core until the slave answers and aborts transfers that wait too long.
module mips_data_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] count_reg;
  logic        request;

  assign request = cpu_read | cpu_write;

  always_comb begin
    state_next = state_reg;
    cpu_stall  = 1'b0;
    case (state_reg)
      IDLE: begin
        cpu_stall = request;
        if (request) state_next = ACCESS;
      end
      ACCESS: begin
        cpu_stall = 1'b1;
        if (!mem_waitrequest || count_reg == TIMEOUT_LAST) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= 16'd0;
      mem_address    <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'd0;
      mem_writedata  <= 32'd0;
      cpu_readdata   <= 32'd0;
      bus_error      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (request) begin
            mem_address    <= cpu_address & 32'hFFFF_FFFC;
            mem_byteenable <= cpu_byteenable;
            mem_writedata  <= cpu_writedata;
            // A simultaneous read and write is issued as a write only.
            mem_write      <= cpu_write;
            mem_read       <= cpu_read & ~cpu_write;
            count_reg      <= 16'd0;
          end
        end
        ACCESS: begin
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) cpu_readdata <= mem_readdata;
          end else if (count_reg == TIMEOUT_LAST) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            bus_error <= 1'b1;
            if (mem_read) cpu_readdata <= 32'd0;
          end else if (count_reg != 16'hFFFF) begin
            count_reg <= count_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Randomized scoreboard bench for mips_data_bus_bridge: a transaction-level model
// predicts read data, error flag and stall/strobe lengths for each access.
module tb_mips_data_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_address = 32'd0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [3:0]  cpu_byteenable = 4'd0;
  logic [31:0] cpu_writedata = 32'd0;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'd0;
  logic        mem_waitrequest = 1'b0;
  logic        bus_error;

  mips_data_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_byteenable(cpu_byteenable), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_stall(cpu_stall),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        berr;
    int          stalls;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total = 0;
  int txn_no = 0;

  // Transaction-level model state
  logic [31:0] model_rd = 32'd0;
  logic        model_berr = 1'b0;

  // Memory behaviour for the transfer currently in flight
  int          cur_wait = 0;
  logic [31:0] cur_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor and memory responder, both evaluated on the falling edge
  int          stall_cnt = 0;
  int          strobe_cnt = 0;
  int          wait_seen = 0;
  logic        saw_r = 1'b0;
  logic        saw_w = 1'b0;
  logic        unstable = 1'b0;
  logic [31:0] cap_addr = 32'd0;
  logic [31:0] cap_wdata = 32'd0;
  logic [3:0]  cap_be = 4'd0;

  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0; strobe_cnt = 0; wait_seen = 0;
      saw_r = 1'b0; saw_w = 1'b0; unstable = 1'b0;
      mem_waitrequest = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        if (strobe_cnt == 0) begin
          cap_addr = mem_address; cap_wdata = mem_writedata; cap_be = mem_byteenable;
        end else if (mem_address !== cap_addr || mem_writedata !== cap_wdata ||
                     mem_byteenable !== cap_be) begin
          unstable = 1'b1;
        end
        saw_r = saw_r | mem_read;
        saw_w = saw_w | mem_write;
        strobe_cnt++;
        mem_waitrequest = (wait_seen < cur_wait);
        mem_readdata = cur_rdata;
        if (mem_waitrequest) wait_seen++;
      end else begin
        mem_waitrequest = 1'b0;
        wait_seen = 0;
        mem_readdata = $urandom;
      end
      if (cpu_read || cpu_write) begin
        if (cpu_stall) begin
          stall_cnt++;
        end else begin
          exp_t e;
          total++;
          if (sb.size() == 0) begin
            $display("FAIL completion: got unexpected completion expected none");
          end else begin
            passed++;
            e = sb.pop_front();
            txn_no++;
            $display("txn %0d %s addr=%h rdata=%h berr=%0b stalls=%0d strobes=%0d",
                     txn_no, e.is_write ? "WR" : "RD", cap_addr, cpu_readdata,
                     bus_error, stall_cnt, strobe_cnt);
            chk("readdata", cpu_readdata, e.rdata);
            chk("bus_error", 32'(bus_error), 32'(e.berr));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
            chk("mem_address", cap_addr, e.addr);
            chk("mem_byteenable", 32'(cap_be), 32'(e.be));
            chk("saw_write", 32'(saw_w), 32'(e.is_write));
            chk("saw_read", 32'(saw_r), 32'(!e.is_write));
            chk("outputs_stable", 32'(unstable), 32'd0);
            if (e.is_write) chk("mem_writedata", cap_wdata, e.wdata);
          end
          stall_cnt = 0; strobe_cnt = 0;
          saw_r = 1'b0; saw_w = 1'b0; unstable = 1'b0;
        end
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int w);
    exp_t e;
    bit   timed_out;
    bit   got;
    timed_out = (w >= TO);
    e.is_write = wr;
    e.addr = {addr[31:2], 2'b00};
    e.be = be;
    e.wdata = wdata;
    if (!wr) model_rd = timed_out ? 32'd0 : rdata;
    if (timed_out) model_berr = 1'b1;
    e.rdata = model_rd;
    e.berr = model_berr;
    e.stalls = timed_out ? TO + 1 : w + 2;
    e.strobes = timed_out ? TO : w + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    cur_wait = w; cur_rdata = rdata;
    cpu_read = rd; cpu_write = wr; cpu_address = addr;
    cpu_byteenable = be; cpu_writedata = wdata;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin got = 1; break; end
    end
    if (!got) begin
      $display("FAIL stall_release: got stall stuck expected release");
      $fatal(1, "bridge never released stall");
    end
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_byteenable", 32'(mem_byteenable), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_cpu_readdata", cpu_readdata, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    do_access(1, 0, 32'h1000_0006, 4'hF, 32'd0, 32'hDEADBEEF, 0);
    do_access(0, 1, 32'h2000_0011, 4'b0011, 32'h0000_1234, 32'h5555_AAAA, 3);
    do_access(1, 0, 32'h3000_0008, 4'hF, 32'd0, 32'h1111_2222, 10);
    do_access(1, 0, 32'h3000_000C, 4'hF, 32'd0, 32'hCAFE_F00D, 0);
    do_access(1, 0, 32'h0000_0100, 4'hF, 32'd0, 32'h0BAD_0001, 0);
    do_access(0, 1, 32'h0000_0104, 4'b1100, 32'hA5A5_5A5A, 32'h0, 0);
    do_access(1, 0, 32'h0000_0109, 4'hF, 32'd0, 32'h7777_8888, 0);
    do_access(1, 1, 32'h0000_0200, 4'hF, 32'h1357_9BDF, 32'hFFFF_0000, 1);

    // Reset while a read is waiting inside ACCESS
    @(posedge clk); #1;
    cur_wait = 1000; cur_rdata = 32'h9999_9999;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h4000_0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; cpu_read = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_cpu_readdata", cpu_readdata, 32'd0);
    chk("midrst_bus_error", 32'(bus_error), 32'd0);
    chk("midrst_cpu_stall", 32'(cpu_stall), 32'd0);
    reset = 1'b0;
    model_rd = 32'd0; model_berr = 1'b0;
    @(posedge clk);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] kind;
      logic       rd;
      logic       wr;
      kind = 2'($urandom_range(0, 3));
      rd = kind[0] | (kind == 2'b00);
      wr = kind[1];
      do_access(rd, wr, $urandom, 4'($urandom), $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 3));
    end

    go_idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
